seq_load_sync_ram: RTL and testbench

- Single-port-style synchronous RAM with a streaming write loader: a start command sets base address and beat count, then data beats arrive over a valid/ready handshake and are written to consecutive, wrapping addresses.
- Independent synchronous read port with 1-cycle registered latency, so contents can be read back the same way as the team's sync-read ROM.
- Serves as the write-side companion for table/ROM-image loading.

---
 rtl/seq_load_sync_ram.sv | 124 ++++++++++++
 tb/tb_seq_load_sync_ram.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_load_sync_ram.sv
// Streaming write loader in front of a synchronous RAM, with an independent registered read port.
// Optional feature: define LOADER_CHECKSUM_EN to add a running XOR checksum of accepted beats.
//
// state   | meaning
// --------+-------------------------------------------------
// ST_IDLE | waiting for start; base address and count latched on start
// ST_LOAD | accepting beats, writing consecutive wrapping addresses
// ST_DONE | single-cycle done pulse, then back to idle
module seq_load_sync_ram #(
    parameter int w = 8,
    parameter int d = 16,
    localparam int AW = $clog2(d),
    localparam int CW = $clog2(d) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] ad_wr,
    input  logic [CW-1:0] wr_count,
    input  logic [w-1:0]  data_in,
    input  logic          wr_valid,
    output logic          wr_ready,
    output logic          busy,
    output logic          done,
    input  logic [AW-1:0] ad_rd,
    output logic [w-1:0]  data_out
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [w-1:0]  checksum
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_t;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] addr;
    logic [CW-1:0] remaining;
    logic          start_ok;
    logic          accept;
    logic          last_beat;
    logic [w-1:0]  mem [d];

    assign start_ok  = (state == ST_IDLE) && start;
    assign accept    = (state == ST_LOAD) && wr_valid;
    assign last_beat = accept && (remaining == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = (wr_count != '0) ? ST_LOAD : ST_DONE;
                end
            end
            ST_LOAD: begin
                if (last_beat) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_ready = (state == ST_LOAD);
        busy     = (state != ST_IDLE);
        done     = (state == ST_DONE);
    end

    // Out-of-range base addresses fall back to word 0 rather than writing outside the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            remaining <= '0;
        end else if (start_ok) begin
            addr      <= ({1'b0, ad_wr} < CW'(d)) ? ad_wr : '0;
            remaining <= wr_count;
        end else if (accept) begin
            addr      <= (addr == AW'(d - 1)) ? '0 : addr + AW'(1);
            remaining <= remaining - CW'(1);
        end
    end

    // Array has no reset so loaded contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[addr] <= data_in;
        end
    end

    // Read-first: a same-cycle write to ad_rd shows up on the following read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else if ({1'b0, ad_rd} < CW'(d)) begin
            data_out <= mem[ad_rd];
        end else begin
            data_out <= '0;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (start_ok) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= checksum ^ data_in;
        end
    end
`endif

endmodule

// File: tb/tb_seq_load_sync_ram.sv
// Randomized self-checking bench for seq_load_sync_ram against an array-based memory model.
// Checksum checks are compiled in when LOADER_CHECKSUM_EN is defined.
module tb_seq_load_sync_ram;
    localparam int W  = 8;
    localparam int D  = 16;
    localparam int AW = 4;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] ad_wr;
    logic [CW-1:0] wr_count;
    logic [W-1:0]  data_in;
    logic          wr_valid;
    logic          wr_ready;
    logic          busy;
    logic          done;
    logic [AW-1:0] ad_rd;
    logic [W-1:0]  data_out;
`ifdef LOADER_CHECKSUM_EN
    logic [W-1:0]  checksum;
`endif

    int tests = 0;
    int fails = 0;
    logic [W-1:0] model [D];
    logic [W-1:0] model_sum;

    seq_load_sync_ram #(.w(W), .d(D)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ad_wr(ad_wr), .wr_count(wr_count),
        .data_in(data_in), .wr_valid(wr_valid), .wr_ready(wr_ready), .busy(busy),
        .done(done), .ad_rd(ad_rd), .data_out(data_out)
`ifdef LOADER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int base, input int cnt);
        start = 1'b1;
        ad_wr = AW'(base);
        wr_count = CW'(cnt);
        tick();
        start = 1'b0;
        model_sum = '0;
    endtask

    // Model: beat idx of a load from base lands at (base+idx) mod D.
    task automatic model_write(input int base, input int idx, input logic [W-1:0] v);
        model[(base + idx) % D] = v;
        model_sum = model_sum ^ v;
    endtask

    task automatic send_beat(input logic [W-1:0] v, input int stall);
        int n;
        wr_valid = 1'b0;
        repeat (stall) tick();
        data_in = v;
        wr_valid = 1'b1;
        n = 0;
        while (wr_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (wr_ready !== 1'b1) begin
            tests++; fails++;
            $display("FAIL beat_timeout wr_ready=%b required 1", wr_ready);
        end
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; ad_wr = '0; wr_count = CW'(5);
        data_in = '0; wr_valid = 1'b0; ad_rd = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        start = 1'b0;
        tests++;
        if (data_out !== 8'h00 || busy !== 1'b0 || wr_ready !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs data_out=%h busy=%b wr_ready=%b done=%b required 00/0/0/0",
                     data_out, busy, wr_ready, done);
        end
        tick();
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_start_ignored busy=%b done=%b required 0/0", busy, done);
        end
    endtask

    task automatic test_basic_load();
        int ready_cycles;
        do_start(0, 16);
        ready_cycles = 0;
        for (int i = 0; i < 16; i++) begin
            if (wr_ready === 1'b1) ready_cycles++;
            data_in = 8'hA0 + W'(i);
            wr_valid = 1'b1;
            tick();
            model_write(0, i, 8'hA0 + W'(i));
        end
        wr_valid = 1'b0;
        tests++;
        if (ready_cycles != 16) begin
            fails++;
            $display("FAIL basic_ready_cycles got %0d required 16", ready_cycles);
        end
        tests++;
        if (done !== 1'b1 || wr_ready !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL basic_done done=%b wr_ready=%b busy=%b required 1/0/1", done, wr_ready, busy);
        end
`ifdef LOADER_CHECKSUM_EN
        tests++;
        if (checksum !== model_sum) begin
            fails++;
            $display("FAIL basic_checksum got %h required %h", checksum, model_sum);
        end
`endif
        tick();
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_done_pulse done=%b busy=%b required 0/0", done, busy);
        end
        for (int i = 0; i < 16; i++) begin
            ad_rd = AW'(i);
            tick();
            tests++;
            if (data_out !== model[i]) begin
                fails++;
                $display("FAIL basic_read addr=%0d got %h required %h", i, data_out, model[i]);
            end
        end
    endtask

    task automatic test_wrap_stall();
        logic [W-1:0] vals [4];
        int exp_addr [4];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_addr = '{14, 15, 0, 1};
        do_start(14, 4);
        for (int k = 0; k < 4; k++) begin
            wr_valid = 1'b0;
            for (int s = 0; s < 2; s++) begin
                tick();
                tests++;
                if (done !== 1'b0 || busy !== 1'b1) begin
                    fails++;
                    $display("FAIL wrap_stall beat=%0d done=%b busy=%b required 0/1", k, done, busy);
                end
            end
            data_in = vals[k];
            wr_valid = 1'b1;
            tick();
            model_write(14, k, vals[k]);
            if (k < 3) begin
                tests++;
                if (done !== 1'b0) begin
                    fails++;
                    $display("FAIL wrap_early_done beat=%0d done=%b required 0", k, done);
                end
            end
        end
        wr_valid = 1'b0;
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL wrap_done done=%b required 1", done);
        end
        tick();
        for (int k = 0; k < 4; k++) begin
            ad_rd = AW'(exp_addr[k]);
            tick();
            tests++;
            if (data_out !== vals[k]) begin
                fails++;
                $display("FAIL wrap_read addr=%0d got %h required %h", exp_addr[k], data_out, vals[k]);
            end
        end
    endtask

    task automatic test_zero_and_ignored_start();
        do_start(3, 0);
        tests++;
        if (done !== 1'b1 || wr_ready !== 1'b0) begin
            fails++;
            $display("FAIL zero_done done=%b wr_ready=%b required 1/0", done, wr_ready);
        end
        tick();
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL zero_idle busy=%b done=%b required 0/0", busy, done);
        end
        do_start(4, 4);
        start = 1'b1; ad_wr = AW'(9); wr_count = CW'(1);
        for (int k = 0; k < 4; k++) begin
            logic [W-1:0] v;
            v = W'($urandom);
            send_beat(v, 0);
            model_write(4, k, v);
            if (k < 3) begin
                tests++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    fails++;
                    $display("FAIL ignored_start beat=%0d busy=%b done=%b required 1/0", k, busy, done);
                end
            end
        end
        start = 1'b0;
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL ignored_start_done done=%b required 1", done);
        end
        tick();
        for (int i = 0; i < D; i++) begin
            ad_rd = AW'(i);
            tick();
            tests++;
            if (data_out !== model[i]) begin
                fails++;
                $display("FAIL zero_ignored_read addr=%0d got %h required %h", i, data_out, model[i]);
            end
        end
    endtask

    task automatic test_collision();
        do_start(5, 1);
        send_beat(8'h55, 0);
        model_write(5, 0, 8'h55);
        tick();
        ad_rd = AW'(5);
        do_start(5, 1);
        send_beat(8'h66, 0);
        model_write(5, 0, 8'h66);
        tests++;
        if (data_out !== 8'h55) begin
            fails++;
            $display("FAIL collision_old got %h required 55", data_out);
        end
        tick();
        tests++;
        if (data_out !== 8'h66) begin
            fails++;
            $display("FAIL collision_new got %h required 66", data_out);
        end
    endtask

    task automatic test_random_loads();
        for (int it = 0; it < 8; it++) begin
            int base;
            int cnt;
            base = int'($urandom_range(0, D - 1));
            cnt = int'($urandom_range(0, 2 * D - 4));
            do_start(base, cnt);
            for (int k = 0; k < cnt; k++) begin
                logic [W-1:0] v;
                v = W'($urandom);
                send_beat(v, int'($urandom_range(0, 2)));
                model_write(base, k, v);
            end
            tests++;
            if (done !== 1'b1) begin
                fails++;
                $display("FAIL rand_done iter=%0d count=%0d done=%b required 1", it, cnt, done);
            end
`ifdef LOADER_CHECKSUM_EN
            tests++;
            if (checksum !== model_sum) begin
                fails++;
                $display("FAIL rand_checksum iter=%0d got %h required %h", it, checksum, model_sum);
            end
`endif
            tick();
            for (int i = 0; i < D; i++) begin
                ad_rd = AW'(i);
                tick();
                tests++;
                if (data_out !== model[i]) begin
                    fails++;
                    $display("FAIL rand_read iter=%0d addr=%0d got %h required %h", it, i, data_out, model[i]);
                end
            end
        end
    endtask

    task automatic test_reset_midload();
        logic [W-1:0] vals [3];
        vals = '{8'h01, 8'h02, 8'h04};
        do_start(2, 8);
        for (int k = 0; k < 3; k++) begin
            send_beat(vals[k], 0);
            model[(2 + k) % D] = vals[k];
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || wr_ready !== 1'b0 || data_out !== 8'h00) begin
            fails++;
            $display("FAIL midload_reset done=%b busy=%b wr_ready=%b data_out=%h required 0/0/0/00",
                     done, busy, wr_ready, data_out);
        end
`ifdef LOADER_CHECKSUM_EN
        tests++;
        if (checksum !== 8'h00) begin
            fails++;
            $display("FAIL midload_checksum_reset got %h required 00", checksum);
        end
`endif
        tick();
        rst_n = 1'b1;
        tick();
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL midload_after_reset done=%b busy=%b required 0/0", done, busy);
        end
        for (int k = 0; k < 3; k++) begin
            ad_rd = AW'(2 + k);
            tick();
            tests++;
            if (data_out !== vals[k]) begin
                fails++;
                $display("FAIL midload_retained addr=%0d got %h required %h", 2 + k, data_out, vals[k]);
            end
        end
        do_start(7, 2);
        send_beat(8'h0F, 0);
        model_write(7, 0, 8'h0F);
        send_beat(8'hF0, 1);
        model_write(7, 1, 8'hF0);
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL fresh_done done=%b required 1", done);
        end
`ifdef LOADER_CHECKSUM_EN
        tests++;
        if (checksum !== 8'hFF) begin
            fails++;
            $display("FAIL fresh_checksum got %h required ff", checksum);
        end
        tick();
        tick();
        tests++;
        if (checksum !== 8'hFF) begin
            fails++;
            $display("FAIL checksum_hold got %h required ff", checksum);
        end
`else
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_wrap_stall();
        test_zero_and_ignored_start();
        test_collision();
        test_random_loads();
        test_reset_midload();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached tests=%0d", tests);
        $fatal(1);
    end
endmodule
